ex_stage_slice: RTL and testbench

- Execute slice of the 5-stage RV64 pipeline: forwarding select, operand muxes, ALU control decode, 64-bit ALU, branch-target adder, and the EX/MEM pipeline register.
- Sits between the ID/EX register and the memory-access stage; takes feedback from its own EX/MEM outputs and from the MEM/WB write-back bus.

---
 rtl/pipeline_pkg.sv | 49 ++++
 rtl/alu_core.sv | 62 ++++++
 rtl/ex_stage_slice.sv | 114 +++++++++++
 tb/tb_ex_stage_slice.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV64 pipeline: datapath width, ALU control
// and alu_op encodings, forwarding selects and the forwarding-select rule.
package pipeline_pkg;

    localparam int XLEN = 64;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_ADD2  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // The younger producer (EX/MEM) wins; x0 is never a forwarding source.
    function automatic fwd_sel_t fwd_select(
        input logic       rw_mem,
        input logic [4:0] rd_mem,
        input logic       rw_wb,
        input logic [4:0] rd_wbk,
        input logic [4:0] rs
    );
        if (rw_mem && (rd_mem != 5'd0) && (rd_mem == rs))
            return FWD_MEM;
        else if (rw_wb && (rd_wbk != 5'd0) && (rd_wbk == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/alu_core.sv
// ALU control decode plus the 64-bit ALU; purely combinational.
module alu_core
    import pipeline_pkg::*;
(
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            alu_src,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    alu_ctrl_t  ctrl;
    logic [5:0] shamt;

    assign shamt = b[5:0];

    // funct7b5 only means SUB for register-register ops; ADDI reuses the bit as immediate.
    always_comb begin
        ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD:   ctrl = ALU_ADD;
            ALUOP_SUB:   ctrl = ALU_SUB;
            ALUOP_ADD2:  ctrl = ALU_ADD;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ctrl = (funct7b5 && !alu_src) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    default: ctrl = ALU_AND;
                endcase
            end
            default:     ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage_slice.sv
// Execute stage: forwarding selects, operand muxes, ALU, branch-target adder
// and the EX/MEM pipeline register (loads every cycle, no stall).
module ex_stage_slice
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] immediate,
    input  logic            branch,
    input  logic            mem_read,
    input  logic            mem_to_reg,
    input  logic            mem_write,
    input  logic            alu_src,
    input  logic            reg_write,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            reg_write_wb,
    input  logic [4:0]      rd_wb,
    input  logic [XLEN-1:0] wb_data,
    output logic [1:0]      forward_a,
    output logic [1:0]      forward_b,
    output logic            mem_to_reg_d3,
    output logic            reg_write_d3,
    output logic            branch_d3,
    output logic            mem_read_d3,
    output logic            mem_write_d3,
    output logic [XLEN-1:0] pc_branch_d3,
    output logic [XLEN-1:0] alu_result_d3,
    output logic            alu_zero_d3,
    output logic [XLEN-1:0] rs2_data_d3,
    output logic [4:0]      rd_d3
);

    fwd_sel_t        sel_a;
    fwd_sel_t        sel_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic [XLEN-1:0] pc_branch;

    assign sel_a     = fwd_select(reg_write_d3, rd_d3, reg_write_wb, rd_wb, rs1);
    assign sel_b     = fwd_select(reg_write_d3, rd_d3, reg_write_wb, rd_wb, rs2);
    assign forward_a = sel_a;
    assign forward_b = sel_b;

    always_comb begin
        op_a = rs1_data;
        case (sel_a)
            FWD_MEM: op_a = alu_result_d3;
            FWD_WB:  op_a = wb_data;
            default: op_a = rs1_data;
        endcase
    end

    always_comb begin
        fwd_b = rs2_data;
        case (sel_b)
            FWD_MEM: fwd_b = alu_result_d3;
            FWD_WB:  fwd_b = wb_data;
            default: fwd_b = rs2_data;
        endcase
    end

    assign alu_b     = alu_src ? immediate : fwd_b;
    assign pc_branch = pc + immediate;

    alu_core u_alu_core (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_src  (alu_src),
        .a        (op_a),
        .b        (alu_b),
        .result   (alu_result),
        .zero     (alu_zero)
    );

    // Store data keeps the forwarded rs2 value, not the immediate picked for the ALU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_to_reg_d3 <= 1'b0;
            reg_write_d3  <= 1'b0;
            branch_d3     <= 1'b0;
            mem_read_d3   <= 1'b0;
            mem_write_d3  <= 1'b0;
            pc_branch_d3  <= '0;
            alu_result_d3 <= '0;
            alu_zero_d3   <= 1'b0;
            rs2_data_d3   <= '0;
            rd_d3         <= '0;
        end else begin
            mem_to_reg_d3 <= mem_to_reg;
            reg_write_d3  <= reg_write;
            branch_d3     <= branch;
            mem_read_d3   <= mem_read;
            mem_write_d3  <= mem_write;
            pc_branch_d3  <= pc_branch;
            alu_result_d3 <= alu_result;
            alu_zero_d3   <= alu_zero;
            rs2_data_d3   <= fwd_b;
            rd_d3         <= rd;
        end
    end

endmodule

// File: tb/tb_ex_stage_slice.sv
// Self-checking bench for ex_stage_slice: directed scenarios plus randomized
// traffic compared against a behavioural model of the execute stage.
module tb_ex_stage_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc, rs1_data, rs2_data, immediate, wb_data;
    logic [4:0]  rs1, rs2, rd, rd_wb;
    logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7b5, reg_write_wb;
    logic [1:0]  forward_a, forward_b;
    logic        mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3;
    logic [63:0] pc_branch_d3, alu_result_d3, rs2_data_d3;
    logic        alu_zero_d3;
    logic [4:0]  rd_d3;

    int total = 0;
    int bad   = 0;

    // Model of what the EX/MEM register should hold
    logic        m_mem_to_reg, m_reg_write, m_branch, m_mem_read, m_mem_write, m_zero;
    logic [63:0] m_pc_branch, m_result, m_rs2;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    ex_stage_slice dut (
        .clk(clk), .rst(rst), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1(rs1), .rs2(rs2), .rd(rd), .immediate(immediate), .branch(branch),
        .mem_read(mem_read), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write), .alu_op(alu_op), .funct3(funct3),
        .funct7b5(funct7b5), .reg_write_wb(reg_write_wb), .rd_wb(rd_wb), .wb_data(wb_data),
        .forward_a(forward_a), .forward_b(forward_b), .mem_to_reg_d3(mem_to_reg_d3),
        .reg_write_d3(reg_write_d3), .branch_d3(branch_d3), .mem_read_d3(mem_read_d3),
        .mem_write_d3(mem_write_d3), .pc_branch_d3(pc_branch_d3), .alu_result_d3(alu_result_d3),
        .alu_zero_d3(alu_zero_d3), .rs2_data_d3(rs2_data_d3), .rd_d3(rd_d3)
    );

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (m_reg_write && m_rd != 0 && m_rd == rs) return 2'b10;
        if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] ref_operand(input logic [1:0] sel, input logic [63:0] rf);
        if (sel == 2'b10) return m_result;
        if (sel == 2'b01) return wb_data;
        return rf;
    endfunction

    // Instruction semantics straight from the RV64 definitions
    function automatic logic [63:0] ref_exec(input logic [1:0] op, input logic [2:0] f3,
                                             input logic f7, input logic src,
                                             input logic [63:0] a, input logic [63:0] b);
        int sh;
        sh = int'(b[5:0]);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f3)
            3'd0: return (f7 && !src) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: return (a < b) ? 64'd1 : 64'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 64'($signed(a) >>> sh) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Predict the next EX/MEM contents, clock once, then settle
    task automatic tick();
        logic [63:0] a, bf, r;
        a  = ref_operand(ref_fwd(rs1), rs1_data);
        bf = ref_operand(ref_fwd(rs2), rs2_data);
        r  = ref_exec(alu_op, funct3, funct7b5, alu_src, a, alu_src ? immediate : bf);
        @(posedge clk);
        if (!rst) begin
            {m_mem_to_reg, m_reg_write, m_branch, m_mem_read, m_mem_write, m_zero} = '0;
            m_pc_branch = '0; m_result = '0; m_rs2 = '0; m_rd = '0;
        end else begin
            m_mem_to_reg = mem_to_reg; m_reg_write = reg_write; m_branch = branch;
            m_mem_read = mem_read; m_mem_write = mem_write;
            m_pc_branch = pc + immediate; m_result = r; m_zero = (r == 0);
            m_rs2 = bf; m_rd = rd;
        end
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 1'b1; pc = 0; rs1_data = 0; rs2_data = 0; immediate = 0; wb_data = 0;
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd10; rd_wb = 0;
        {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write} = '0;
        alu_op = 2'b10; funct3 = 0; funct7b5 = 0; reg_write_wb = 0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        rst = 1'b0; pc = 64'h1234; rs1_data = 64'h55; rs2_data = 64'h66; immediate = 64'h8;
        {branch, mem_read, mem_to_reg, mem_write, reg_write} = '1; rd = 5'd9;
        tick(); tick();
        total++;
        if ({mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3, alu_zero_d3} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 000000",
                {mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3, alu_zero_d3});
        end
        total++;
        if ({pc_branch_d3, alu_result_d3, rs2_data_d3, rd_d3} !== '0) begin
            bad++; $display("FAIL reset_data: pc_branch=%h result=%h rs2=%h rd=%0d want all 0",
                pc_branch_d3, alu_result_d3, rs2_data_d3, rd_d3);
        end
        rs1 = 5'd9; rs2 = 5'd9; #1;
        total++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            bad++; $display("FAIL reset_fwd: got %b/%b want 00/00", forward_a, forward_b);
        end
        quiet_inputs(); tick();
    endtask

    task automatic test_rtype();
        logic [63:0] want [3];
        logic        wz   [3];
        want = '{64'd12, 64'd2, 64'd0};
        wz   = '{1'b0, 1'b0, 1'b1};
        quiet_inputs();
        for (int i = 0; i < 3; i++) begin
            funct7b5 = (i != 0);
            rs1_data = (i == 2) ? 64'd5 : 64'd7;
            rs2_data = 64'd5;
            tick();
            total++;
            if (alu_result_d3 !== want[i] || alu_zero_d3 !== wz[i]) begin
                bad++; $display("FAIL rtype_%0d: got %0d zero=%b want %0d zero=%b",
                    i, alu_result_d3, alu_zero_d3, want[i], wz[i]);
            end
        end
    endtask

    task automatic test_fwd_mem();
        quiet_inputs();
        rd = 5'd3; reg_write = 1; rs1_data = 7; rs2_data = 5; tick();
        rs1 = 5'd3; rs2 = 5'd3; rs1_data = 1; rs2_data = 2; rd = 5'd11; reg_write = 0; #1;
        total++;
        if (forward_a !== 2'b10 || forward_b !== 2'b10) begin
            bad++; $display("FAIL fwd_mem_sel: got %b/%b want 10/10", forward_a, forward_b);
        end
        tick();
        total++;
        if (alu_result_d3 !== 64'd24) begin
            bad++; $display("FAIL fwd_mem_result: got %0d want 24", alu_result_d3);
        end
        rs1 = 5'd1; rs2 = 5'd2; rd = 5'd0; reg_write = 1; rs1_data = 7; rs2_data = 5; tick();
        rs1 = 5'd0; rs2 = 5'd0; rs1_data = 1; rs2_data = 2; reg_write = 0; rd = 5'd11; #1;
        total++;
        if (forward_a !== 2'b00 || forward_b !== 2'b00) begin
            bad++; $display("FAIL fwd_x0_sel: got %b/%b want 00/00", forward_a, forward_b);
        end
        tick();
        total++;
        if (alu_result_d3 !== 64'd3) begin
            bad++; $display("FAIL fwd_x0_result: got %0d want 3", alu_result_d3);
        end
    endtask

    task automatic test_priority();
        quiet_inputs();
        rd = 5'd4; reg_write = 1; rs1_data = 7; rs2_data = 5; tick();
        rs1 = 5'd4; rs2 = 5'd2; rs2_data = 0; rs1_data = 64'd1000;
        rd_wb = 5'd4; reg_write_wb = 1; wb_data = 64'd99; reg_write = 0; rd = 5'd12; #1;
        total++;
        if (forward_a !== 2'b10) begin
            bad++; $display("FAIL prio_mem_sel: got %b want 10", forward_a);
        end
        tick();
        total++;
        if (alu_result_d3 !== 64'd12) begin
            bad++; $display("FAIL prio_mem_result: got %0d want 12", alu_result_d3);
        end
        total++;
        if (forward_a !== 2'b01) begin
            bad++; $display("FAIL prio_wb_sel: got %b want 01", forward_a);
        end
        tick();
        total++;
        if (alu_result_d3 !== 64'd99) begin
            bad++; $display("FAIL prio_wb_result: got %0d want 99", alu_result_d3);
        end
    endtask

    task automatic test_store_branch();
        quiet_inputs();
        alu_op = 2'b00; alu_src = 1; mem_write = 1; rs1_data = 64'd100; immediate = 64'd8;
        rs2 = 5'd7; rs2_data = 0; rd_wb = 5'd7; reg_write_wb = 1; wb_data = 64'd55; #1;
        total++;
        if (forward_b !== 2'b01) begin
            bad++; $display("FAIL store_sel: got %b want 01", forward_b);
        end
        tick();
        total++;
        if (alu_result_d3 !== 64'd108 || rs2_data_d3 !== 64'd55 || mem_write_d3 !== 1'b1) begin
            bad++; $display("FAIL store: result=%0d rs2=%0d mw=%b want 108 55 1",
                alu_result_d3, rs2_data_d3, mem_write_d3);
        end
        mem_write = 0; branch = 1; pc = 64'h40; immediate = -64'sd16; tick();
        total++;
        if (pc_branch_d3 !== 64'h30 || branch_d3 !== 1'b1) begin
            bad++; $display("FAIL branch_target: got %h br=%b want 30 1", pc_branch_d3, branch_d3);
        end
    endtask

    task automatic test_shift_cmp();
        logic [2:0]  f3s  [4];
        logic        f7s  [4];
        logic [63:0] as   [4];
        logic [63:0] want [4];
        f3s  = '{3'd5, 3'd5, 3'd2, 3'd3};
        f7s  = '{1'b1, 1'b0, 1'b0, 1'b0};
        as   = '{64'h8000000000000000, 64'h8000000000000000, '1, '1};
        want = '{64'hF800000000000000, 64'h0800000000000000, 64'd1, 64'd0};
        quiet_inputs();
        for (int i = 0; i < 4; i++) begin
            alu_src  = (i < 2);
            immediate = 64'd4;
            rs2_data = 64'd1;
            funct3 = f3s[i]; funct7b5 = f7s[i]; rs1_data = as[i];
            tick();
            total++;
            if (alu_result_d3 !== want[i]) begin
                bad++; $display("FAIL shift_cmp_%0d: got %h want %h", i, alu_result_d3, want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] ea, eb;
        quiet_inputs();
        for (int i = 0; i < 300; i++) begin
            rst = ($urandom_range(0, 19) != 0);
            pc = {$urandom, $urandom}; immediate = {$urandom, $urandom};
            rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
            wb_data = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rs2_data = rs1_data;
            rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3)); rd_wb = 5'($urandom_range(0, 3));
            {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write} = 6'($urandom);
            alu_op = 2'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
            reg_write_wb = 1'($urandom);
            #1;
            ea = ref_fwd(rs1); eb = ref_fwd(rs2);
            total++;
            if (forward_a !== ea || forward_b !== eb) begin
                bad++; $display("FAIL rand_fwd[%0d]: got %b/%b want %b/%b", i, forward_a, forward_b, ea, eb);
            end
            tick();
            total++;
            if ({mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3, alu_zero_d3, rd_d3}
                !== {m_mem_to_reg, m_reg_write, m_branch, m_mem_read, m_mem_write, m_zero, m_rd}) begin
                bad++; $display("FAIL rand_ctrl[%0d]: got %b%b%b%b%b z=%b rd=%0d want %b%b%b%b%b z=%b rd=%0d", i,
                    mem_to_reg_d3, reg_write_d3, branch_d3, mem_read_d3, mem_write_d3, alu_zero_d3, rd_d3,
                    m_mem_to_reg, m_reg_write, m_branch, m_mem_read, m_mem_write, m_zero, m_rd);
            end
            total++;
            if (alu_result_d3 !== m_result || pc_branch_d3 !== m_pc_branch || rs2_data_d3 !== m_rs2) begin
                bad++; $display("FAIL rand_data[%0d]: got res=%h pcb=%h rs2=%h want res=%h pcb=%h rs2=%h", i,
                    alu_result_d3, pc_branch_d3, rs2_data_d3, m_result, m_pc_branch, m_rs2);
            end
        end
    endtask

    initial begin
        {m_mem_to_reg, m_reg_write, m_branch, m_mem_read, m_mem_write, m_zero} = '0;
        m_pc_branch = '0; m_result = '0; m_rs2 = '0; m_rd = '0;
        quiet_inputs();
        rst = 1'b0;
        test_reset();
        test_rtype();
        test_fwd_mem();
        test_priority();
        test_store_branch();
        test_shift_cmp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
